// File: rtl/fp_add_result_stage.sv
// ---------------------------------------------------------------------------
// Module : fp_add_result_stage
// Brief  : Output buffer for an FP adder: DEPTH-entry FIFO, class decode,
//          sticky overflow/underflow flags and delivered-result counter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fp_add_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_overflow,
  input  logic        in_underflow,
  input  logic [4:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_tag,
  output logic [4:0]  out_class,
  input  logic        flags_clr,
  output logic [1:0]  sticky_flags,
  output logic [15:0] op_count
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(DEPTH - 1);

  logic [31:0]      r_mem_result [DEPTH];
  logic [4:0]       r_mem_tag    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_sticky;
  logic [15:0]      r_op_count;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_exp;
  logic             w_frac_nz;

  assign in_ready  = (r_count < C_DEPTH);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_result   = r_mem_result[r_rd_ptr];
  assign out_tag      = r_mem_tag[r_rd_ptr];
  assign sticky_flags = r_sticky;
  assign op_count     = r_op_count;

  assign w_exp     = out_result[30:23];
  assign w_frac_nz = |out_result[22:0];

  always_comb begin
    out_class = 5'b00000;
    if (out_valid) begin
      if (w_exp == 8'hFF)      out_class = w_frac_nz ? 5'b10000 : 5'b01000;
      else if (w_exp == 8'h00) out_class = w_frac_nz ? 5'b00010 : 5'b00001;
      else                     out_class = 5'b00100;
    end
  end

  // Storage is intentionally not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= in_result;
      r_mem_tag[r_wr_ptr]    <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sticky   <= 2'b00;
      r_op_count <= 16'd0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == C_PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == C_PTR_MAX) ? '0 : r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;

      // A same-cycle push wins over clear: clear the old value, then OR in.
      if (w_push)         r_sticky <= (flags_clr ? 2'b00 : r_sticky) | {in_overflow, in_underflow};
      else if (flags_clr) r_sticky <= 2'b00;

      if (flags_clr)                         r_op_count <= w_pop ? 16'd1 : 16'd0;
      else if (w_pop && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_add_result_stage.sv
// ---------------------------------------------------------------------------
// Module : tb_fp_add_result_stage
// Brief  : Directed self-checking bench for fp_add_result_stage (DEPTH=2).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_add_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_underflow;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [4:0]  out_class;
  logic        flags_clr;
  logic [1:0]  sticky_flags;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  fp_add_result_stage #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_class    (out_class),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic o,
                       input logic u, input logic [4:0] t);
    in_valid     = v;
    in_result    = r;
    in_overflow  = o;
    in_underflow = u;
    in_tag       = t;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sticky",    32'(sticky_flags), 32'd0);
    chk("rst_op_count",  32'(op_count),  32'd0);
    chk("rst_class",     32'(out_class), 32'd0);
    #9 rst_n = 1'b1;
    tick;

    // One-cycle latency, normal class, op_count after pop
    drive(1'b1, 32'h3F800000, 1'b0, 1'b0, 5'd3);
    out_ready = 1'b1;
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("lat_valid",  32'(out_valid),  32'd1);
    chk("lat_result", out_result,      32'h3F800000);
    chk("lat_tag",    32'(out_tag),    32'd3);
    chk("lat_class",  32'(out_class),  32'b00100);
    chk("lat_cnt0",   32'(op_count),   32'd0);
    tick;
    chk("lat_cnt1",   32'(op_count),   32'd1);
    chk("lat_empty",  32'(out_valid),  32'd0);
    chk("lat_class0", 32'(out_class),  32'd0);

    // Fill with Inf (ovf) then subnormal (udf)
    out_ready = 1'b0;
    drive(1'b1, 32'h7F800000, 1'b1, 1'b0, 5'd1);
    tick;
    drive(1'b1, 32'h00000001, 1'b0, 1'b1, 5'd2);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("full_in_ready", 32'(in_ready),     32'd0);
    chk("full_sticky",   32'(sticky_flags), 32'b11);
    chk("full_class_inf", 32'(out_class),   32'b01000);
    chk("full_tag1",     32'(out_tag),      32'd1);

    // Full: push attempt with pop in same cycle must only pop
    out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 5'd9);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("fullpop_in_ready", 32'(in_ready),   32'd1);
    chk("fullpop_class_sub", 32'(out_class), 32'b00010);
    chk("fullpop_result",   out_result,      32'h00000001);
    chk("fullpop_tag",      32'(out_tag),    32'd2);
    chk("fullpop_cnt",      32'(op_count),   32'd2);
    tick;
    chk("fullpop_nopush", 32'(out_valid), 32'd0);
    chk("fullpop_cnt3",   32'(op_count),  32'd3);

    // Clear with same-cycle push: set wins
    out_ready = 1'b0;
    flags_clr = 1'b1;
    drive(1'b1, 32'h80000000, 1'b1, 1'b0, 5'd4);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("clr_push_sticky", 32'(sticky_flags), 32'b10);
    chk("clr_push_cnt",    32'(op_count),     32'd0);
    chk("negzero_class",   32'(out_class),    32'b00001);
    tick;
    chk("clr_only_sticky", 32'(sticky_flags), 32'b00);
    chk("clr_only_cnt",    32'(op_count),     32'd0);
    out_ready = 1'b1;
    tick;
    chk("clr_pop_cnt", 32'(op_count), 32'd1);
    out_ready = 1'b0;
    tick;
    flags_clr = 1'b0;
    chk("clr_cnt_zero", 32'(op_count), 32'd0);

    // Stream of 10 with push and pop every cycle (exercises pointer wrap)
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40000000 + 32'(i), 1'b0, 1'b0, 5'(i + 10));
      tick;
      chk("stream_result",   out_result,       32'h40000000 + 32'(i));
      chk("stream_tag",      32'(out_tag),     32'(i + 10));
      chk("stream_in_ready", 32'(in_ready),    32'd1);
      chk("stream_cnt",      32'(op_count),    32'(i));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick;
    chk("stream_final_cnt", 32'(op_count),  32'd10);
    chk("stream_drained",   32'(out_valid), 32'd0);

    // NaN classification
    out_ready = 1'b0;
    drive(1'b1, 32'hFFC00001, 1'b0, 1'b0, 5'd31);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("nan_class", 32'(out_class), 32'b10000);
    chk("nan_tag",   32'(out_tag),   32'd31);

    // Mid-operation reset with 2 entries buffered
    drive(1'b1, 32'h3F000000, 1'b1, 1'b1, 5'd5);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid),    32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),     32'd1);
    chk("mid_rst_sticky",    32'(sticky_flags), 32'd0);
    chk("mid_rst_cnt",       32'(op_count),     32'd0);
    chk("mid_rst_class",     32'(out_class),    32'd0);
    #2 rst_n = 1'b1;

    // First push after reset accepted, old entries gone
    drive(1'b1, 32'h41200000, 1'b0, 1'b0, 5'd7);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    chk("post_rst_valid",  32'(out_valid), 32'd1);
    chk("post_rst_result", out_result,     32'h41200000);
    chk("post_rst_tag",    32'(out_tag),   32'd7);
    chk("post_rst_ready",  32'(in_ready),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_add_result_stage.md
FP_ADD_RESULT_STAGE -- requirements
Module: fp_add_result_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning result-buffer entry count (legal values 2 or 4).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the adder result on in_* is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the stage accepts a result this cycle.
REQ-006 SHALL have port in_result, input, 32 bits, meaning the adder fp_result (IEEE-754 single).
REQ-007 SHALL have port in_overflow, input, 1 bit, meaning the adder overflow flag.
REQ-008 SHALL have port in_underflow, input, 1 bit, meaning the adder underflow flag.
REQ-009 SHALL have port in_tag, input, 5 bits, meaning the destination tag carried with the result.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the head entry is presented on out_*.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the head entry.
REQ-012 SHALL have port out_result, output, 32 bits, meaning the head entry result.
REQ-013 SHALL have port out_tag, output, 5 bits, meaning the head entry tag.
REQ-014 SHALL have port out_class, output, 5 bits, meaning one-hot class of out_result: [4] NaN, [3] Inf, [2] normal, [1] subnormal, [0] zero.
REQ-015 SHALL have port flags_clr, input, 1 bit, meaning clear sticky flags and op counter.
REQ-016 SHALL have port sticky_flags, output, 2 bits, meaning accumulated {overflow, underflow}.
REQ-017 SHALL have port op_count, output, 16 bits, meaning number of results delivered downstream.

Function
REQ-018 SHALL implement a DEPTH-entry FIFO of {result, overflow, underflow, tag} with read/write pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (occupancy < DEPTH), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL equal (occupancy != 0); out_result/out_tag/out_class SHALL reflect the head entry combinationally from storage.
REQ-022 Latency SHALL be one cycle: a result pushed into an empty buffer appears with out_valid=1 in the next cycle.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; when full, no push occurs even if out_ready=1 that cycle.
REQ-024 out_class: exp=0xFF & frac!=0 -> NaN; exp=0xFF & frac=0 -> Inf; exp=0 & frac=0 -> zero (either sign); exp=0 & frac!=0 -> subnormal; otherwise normal; exactly one bit set while out_valid=1, all zero while out_valid=0.
REQ-025 sticky_flags SHALL OR in {in_overflow, in_underflow} on each push; bits never clear except by flags_clr or reset.
REQ-026 flags_clr with a same-cycle push SHALL result in sticky_flags equal to the pushed flags (set wins over clear).
REQ-027 op_count SHALL increment by 1 on each pop, saturating at 0xFFFF; flags_clr SHALL zero it, and a same-cycle pop SHALL yield 1.
REQ-028 in_* contents SHALL be ignored when the push condition is false; out_* data while out_valid=0 is don't-care except out_class.
REQ-029 Pointer wrap SHALL not lose or duplicate entries across any number of push/pop cycles.

Reset
REQ-030 rst_n=0 SHALL immediately force occupancy=0, pointers=0, out_valid=0, in_ready=1, sticky_flags=0, op_count=0, out_class=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; FIFO storage contents need not be cleared.
REQ-032 After rst_n deasserts, first push SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-033 Push 0x3F800000 tag 3 into empty buffer, out_ready=1 -> next cycle out_valid=1, out_result=0x3F800000, out_tag=3, out_class=5'b00100; following cycle op_count=1.
REQ-034 out_ready=0, push 0x7F800000 (ovf=1) then 0x00000001 (udf=1) -> in_ready=0 after second push, sticky_flags=2'b11, head class 5'b01000 then 5'b00010 after pops in order.
REQ-035 Full buffer, out_ready=1 and in_valid=1 same cycle -> one pop, no push, occupancy DEPTH-1, in_ready=1 next cycle.
REQ-036 Stream 10 results with in_valid=out_ready=1 every cycle -> all 10 emerge in order, op_count=10, occupancy stays 1.
REQ-037 flags_clr=1 with push of ovf=1 same cycle -> sticky_flags=2'b10; flags_clr alone next cycle -> 2'b00 and op_count=0.
REQ-038 Assert rst_n=0 with 2 entries buffered -> out_valid=0, in_ready=1, sticky_flags=0 before the next clock edge.
